// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory requests, in-order instruction queue
// Optional feature macro: FETCH_BYPASS_EN (zero-latency response-to-decode bypass)
module fetch_unit #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pcplus4
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [31:0]      fetch_pc;
   logic [31:0]      rsp_pc;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] occupancy;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      buf_instr [BUF_DEPTH];
   logic [31:0]      buf_pc    [BUF_DEPTH];

   logic             req_fire;
   logic             rsp_keep;
   logic             head_valid;
   logic             push;
   logic             pop;
   logic [CNT_W:0]   credit_used;
   logic [31:0]      redirect_base;
   logic             unused_redirect_bits;

   // Credit uses only registered counts so decode ready never reaches the request side
   assign credit_used    = {1'b0, occupancy} + {1'b0, inflight};
   assign imem_req_valid = !redirect && (credit_used < (CNT_W + 1)'(BUF_DEPTH));
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses are kept only when no stale words remain and no flush is happening now
   assign rsp_keep       = imem_rsp_valid && (discard == '0) && !redirect;
   assign head_valid     = (occupancy != '0);
   assign pop            = head_valid && instr_ready;

   assign redirect_base        = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_bits = ^redirect_pc[1:0];

`ifdef FETCH_BYPASS_EN
   logic bypass_take;

   // Empty queue: a kept response goes straight to decode, and skips the queue if consumed
   assign bypass_take = rsp_keep && !head_valid;
   assign instr_valid = head_valid || bypass_take;
   assign instr       = bypass_take ? imem_rsp_data : buf_instr[rd_ptr];
   assign instr_pc    = bypass_take ? rsp_pc : buf_pc[rd_ptr];
   assign push        = rsp_keep && !(bypass_take && instr_ready);
`else
   assign instr_valid = head_valid;
   assign instr       = buf_instr[rd_ptr];
   assign instr_pc    = buf_pc[rd_ptr];
   assign push        = rsp_keep;
`endif

   assign instr_pcplus4 = instr_pc + 32'd4;

   // Program counters and outstanding/stale response bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= PC_RESET;
         rsp_pc   <= PC_RESET;
         inflight <= '0;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_base;
         rsp_pc   <= redirect_base;
         inflight <= inflight - CNT_W'(imem_rsp_valid);
         discard  <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (rsp_keep) begin
            rsp_pc <= rsp_pc + 32'd4;
         end
         inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
         if (imem_rsp_valid && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
         end
      end
   end

   // Instruction queue: circular buffer, cleared wholesale by redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= PC_RESET;
         end
      end else if (redirect) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            buf_instr[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]    <= rsp_pc;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule
